// File: rtl/neuron_accumulator_pkg.sv
// Shared definitions for the dense-layer output stage.
//   DATA_WIDTH_DEFAULT : default width of activations, weights, sums and outputs
//   count_width()      : bits needed for a 0..n-1 counter (never less than 1)
//   relu_clamp()       : decides from the sum's sign bit whether ReLU forces 0
package neuron_accumulator_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    function automatic int unsigned count_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Takes only the sign bit, so it serves any data width.
    function automatic logic relu_clamp(input logic msb, input logic relu_on);
        return relu_on & msb;
    endfunction

endpackage

// File: rtl/neuron_accumulator_mac.sv
// Combinational multiply-accumulate step.
//   activation  : signed activation
//   weight      : signed weight
//   accumulator : running sum of the current neuron
//   sum         : accumulator + low DATA_WIDTH bits of activation*weight (wraps)
module neuron_mac
    import neuron_accumulator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic signed [DATA_WIDTH-1:0] activation,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic signed [DATA_WIDTH-1:0] accumulator,
    output logic signed [DATA_WIDTH-1:0] sum
);

    logic signed [DATA_WIDTH-1:0] product;

    // A DATA_WIDTH-wide result keeps exactly the low bits of the full product.
    always_comb begin
        product = activation * weight;
        sum     = accumulator + product;
    end

endmodule

// File: rtl/neuron_accumulator.sv
// Dense-layer output stage feeding the argmax cell.
//   clk           : system clock, rising edge
//   reset_n       : asynchronous active-low reset
//   input_data    : signed activation
//   input_weight  : signed weight
//   input_enable  : pair valid this cycle
//   input_clear   : synchronous abort of the current inference (wins over enable)
//   output_index  : neuron number of the emitted value
//   output_value  : neuron sum, clamped at 0 when RELU=1
//   output_enable : one-cycle strobe, index/value valid while high
module neuron_accumulator
    import neuron_accumulator_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int unsigned INPUT_AMOUNT  = 4,
    parameter int unsigned NEURON_AMOUNT = 2,
    parameter int unsigned RELU          = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic [DATA_WIDTH-1:0] input_weight,
    input  logic                  input_enable,
    input  logic                  input_clear,
    output logic [DATA_WIDTH-1:0] output_index,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic                  output_enable
);

    localparam int unsigned IW = count_width(INPUT_AMOUNT);
    localparam int unsigned NW = count_width(NEURON_AMOUNT);

    logic [DATA_WIDTH-1:0] accumulator;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] relu_value;
    logic [IW-1:0]         input_count;
    logic [NW-1:0]         neuron_count;
    logic                  last_pair;
    logic                  last_neuron;

    neuron_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .activation  (input_data),
        .weight      (input_weight),
        .accumulator (accumulator),
        .sum         (sum)
    );

    always_comb begin
        last_pair   = (input_count == IW'(INPUT_AMOUNT - 1));
        last_neuron = (neuron_count == NW'(NEURON_AMOUNT - 1));
        relu_value  = relu_clamp(sum[DATA_WIDTH-1], RELU != 0) ? '0 : sum;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accumulator   <= '0;
            input_count   <= '0;
            neuron_count  <= '0;
            output_index  <= '0;
            output_value  <= '0;
            output_enable <= 1'b0;
        end else if (input_clear) begin
            accumulator   <= '0;
            input_count   <= '0;
            neuron_count  <= '0;
            output_enable <= 1'b0;
        end else begin
            output_enable <= 1'b0;
            if (input_enable) begin
                if (last_pair) begin
                    output_value  <= relu_value;
                    output_index  <= DATA_WIDTH'(neuron_count);
                    output_enable <= 1'b1;
                    accumulator   <= '0;
                    input_count   <= '0;
                    neuron_count  <= last_neuron ? '0 : neuron_count + 1'b1;
                end else begin
                    accumulator <= sum;
                    input_count <= input_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench: one RELU=1 and one RELU=0 instance share all inputs.
module tb_neuron_accumulator;

    localparam int unsigned DW = 32;
    localparam int unsigned IA = 2;
    localparam int unsigned NA = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] input_data = '0;
    logic [DW-1:0] input_weight = '0;
    logic          input_enable = 1'b0;
    logic          input_clear = 1'b0;

    logic [DW-1:0] index_r1, value_r1, index_r0, value_r0;
    logic          enable_r1, enable_r0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_accumulator #(
        .DATA_WIDTH (DW), .INPUT_AMOUNT (IA), .NEURON_AMOUNT (NA), .RELU (1)
    ) dut_relu (
        .clk (clk), .reset_n (reset_n),
        .input_data (input_data), .input_weight (input_weight),
        .input_enable (input_enable), .input_clear (input_clear),
        .output_index (index_r1), .output_value (value_r1), .output_enable (enable_r1)
    );

    neuron_accumulator #(
        .DATA_WIDTH (DW), .INPUT_AMOUNT (IA), .NEURON_AMOUNT (NA), .RELU (0)
    ) dut_lin (
        .clk (clk), .reset_n (reset_n),
        .input_data (input_data), .input_weight (input_weight),
        .input_enable (input_enable), .input_clear (input_clear),
        .output_index (index_r0), .output_value (value_r0), .output_enable (enable_r0)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: collect the products of a neuron, sum them once all have arrived.
    logic [DW-1:0] prods[$];
    int unsigned   neurons_done = 0;
    logic          exp_en = 1'b0;
    logic [DW-1:0] exp_idx = '0, exp_v1 = '0, exp_v0 = '0;

    always @(posedge clk) begin
        logic [DW-1:0] p, total;
        if (!reset_n) begin
            prods.delete();
            neurons_done = 0;
            exp_en  = 1'b0;
            exp_idx = '0;
            exp_v1  = '0;
            exp_v0  = '0;
        end else if (input_clear) begin
            prods.delete();
            neurons_done = 0;
            exp_en = 1'b0;
        end else if (input_enable) begin
            p = input_data * input_weight;
            prods.push_back(p);
            if (prods.size() == IA) begin
                total = '0;
                foreach (prods[k]) total = total + prods[k];
                exp_idx = neurons_done;
                exp_v0  = total;
                exp_v1  = ($signed(total) < 0) ? '0 : total;
                exp_en  = 1'b1;
                neurons_done = (neurons_done + 1) % NA;
                prods.delete();
            end else begin
                exp_en = 1'b0;
            end
        end else begin
            exp_en = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("en_relu", {31'd0, enable_r1}, {31'd0, exp_en});
        chk("en_lin",  {31'd0, enable_r0}, {31'd0, exp_en});
        chk("idx_relu", index_r1, exp_idx);
        chk("idx_lin",  index_r0, exp_idx);
        chk("val_relu", value_r1, exp_v1);
        chk("val_lin",  value_r0, exp_v0);
    end

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] w, input logic clr);
        @(negedge clk);
        input_data   = d;
        input_weight = w;
        input_enable = 1'b1;
        input_clear  = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            input_enable = 1'b0;
            input_clear  = 1'b0;
        end
    endtask

    // Hand-computed literal expectation for the edge that consumes the last driven pair.
    task automatic beat(input string name, input logic [DW-1:0] idx,
                        input logic [DW-1:0] v1, input logic [DW-1:0] v0);
        @(posedge clk);
        #2;
        chk({name, "_en"}, {31'd0, enable_r1 & enable_r0}, 32'd1);
        chk({name, "_idx"}, index_r1, idx);
        chk({name, "_v1"}, value_r1, v1);
        chk({name, "_v0"}, value_r0, v0);
    endtask

    task automatic no_beat(input string name);
        @(posedge clk);
        #2;
        chk(name, {31'd0, enable_r1 | enable_r0}, 32'd0);
    endtask

    initial begin
        // Reset held with live inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            input_data   = $urandom;
            input_weight = $urandom;
            input_enable = 1'b1;
        end
        @(posedge clk);
        #2;
        chk("rst_en",  {31'd0, enable_r1 | enable_r0}, 32'd0);
        chk("rst_idx", index_r1 | index_r0, 32'd0);
        chk("rst_val", value_r1 | value_r0, 32'd0);
        @(negedge clk);
        input_enable = 1'b0;
        reset_n = 1'b1;
        idle(1);

        // Nominal inference.
        send(1, 2, 0); send(3, 4, 0); beat("n0", 0, 14, 14);
        send(2, 2, 0); send(1, 1, 0); beat("n1", 1, 5, 5);
        idle(1);
        no_beat("hold_en");
        chk("hold_idx", index_r1, 32'd1);
        chk("hold_val", value_r1, 32'd5);

        // Gaps between pairs, then wrap to neuron 0.
        send(1, 2, 0); idle(3); send(3, 4, 0); beat("g0", 0, 14, 14);
        idle(3);
        send(2, 2, 0); idle(3); send(1, 1, 0); beat("g1", 1, 5, 5);
        send(1, 1, 0); send(1, 1, 0); beat("wrap", 0, 2, 2);

        // Negative sum: clamped by ReLU, passed through otherwise.
        send(-32'sd3, 2, 0); send(1, 1, 0); beat("neg", 1, 0, 32'hFFFF_FFFB);

        // Product overflow truncates to 0.
        send(32'h0001_0000, 32'h0001_0000, 0); send(1, 7, 0); beat("ovf", 0, 7, 7);

        // Clear together with a valid pair drops it and restarts at neuron 0.
        send(5, 5, 0); send(9, 9, 1); no_beat("clr_nobeat");
        send(1, 1, 0); send(1, 1, 0); beat("after_clr", 0, 2, 2);

        // Reset pulse mid-neuron.
        send(5, 5, 0);
        @(negedge clk);
        input_enable = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send(1, 1, 0); send(1, 1, 0); beat("after_rst", 0, 2, 2);

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
